// File: rtl/mtx_types.sv
// Shared types for the matrix unit and its feeders: Q-format elements,
// operand layouts, VLIW opcodes and the operand loader's command/state enums.
package mtx_types;

  localparam int Q     = 23;
  localparam int INT   = 8;
  localparam int TOTAL = 1 + INT + Q;

  localparam int V = 4;
  localparam int R = 4;
  localparam int C = 4;

  typedef logic signed [TOTAL-1:0] qformat_t;
  typedef logic signed [2:0]       val3_t;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    LD_V0 = 3'd1,
    LD_V1 = 3'd2,
    LD_M0 = 3'd3,
    MVMUL = 3'd4,
    VADD  = 3'd5
  } op_t;

  typedef struct packed {
    qformat_t [V-1:0] elements;
  } vec_t;

  typedef struct packed {
    val3_t [R-1:0][C-1:0] elements;
  } mat_t;

  typedef struct packed {
    vec_t vec;
    mat_t mtx;
  } mv_t;

  typedef struct packed {
    op_t op1;
    op_t op2;
    op_t op3;
    op_t op4;
  } vliw_inst_t;

  typedef enum logic [1:0] {
    DEST_V0  = 2'd0,
    DEST_V1  = 2'd1,
    DEST_M0  = 2'd2,
    DEST_BAD = 2'd3
  } ld_dest_t;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_FILL  = 2'd1,
    LD_ISSUE = 2'd2
  } ld_state_t;

  localparam vliw_inst_t NOP_BUNDLE = '{op1: NOP, op2: NOP, op3: NOP, op4: NOP};

  function automatic vliw_inst_t load_bundle(input ld_dest_t d);
    vliw_inst_t b;
    b = NOP_BUNDLE;
    case (d)
      DEST_V0: b.op1 = LD_V0;
      DEST_V1: b.op1 = LD_V1;
      DEST_M0: b.op1 = LD_M0;
      default: b.op1 = NOP;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mtx_operand_loader.sv
// Packs a valid/ready element stream into a complete mv_t operand and issues
// it to the matrix unit as a single load bundle.
module mtx_operand_loader
  import mtx_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_dest,
  input  logic       s_valid,
  output logic       s_ready,
  input  qformat_t   s_data,
  output vliw_inst_t vliw_inst,
  output mv_t        mtx_in,
  output logic       issue,
  output logic       busy,
  output logic       err
);

  localparam int K_W   = $clog2(R*C + 1);
  localparam int ROW_W = $clog2(R);
  localparam int COL_W = $clog2(C);
  localparam int VEC_W = $clog2(V);

  ld_state_t        state, state_next;
  ld_dest_t         dest;
  logic [K_W-1:0]   k;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             last_elem;
  logic             accept_cmd;
  logic             accept_elem;
  logic             legal_cmd;

  assign cmd_ready   = (state == LD_IDLE);
  assign s_ready     = (state == LD_FILL);
  assign accept_cmd  = cmd_ready && cmd_valid;
  assign accept_elem = s_ready && s_valid;
  assign legal_cmd   = (cmd_dest != DEST_BAD);
  assign last_elem   = (dest == DEST_M0) ? (k == K_W'(R*C - 1)) : (k == K_W'(V - 1));

  // NOTE: state_next takes its default before the case so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      LD_IDLE:  if (accept_cmd && legal_cmd) state_next = LD_FILL;
      LD_FILL:  if (accept_elem && last_elem) state_next = LD_ISSUE;
      LD_ISSUE: state_next = LD_IDLE;
      default:  state_next = LD_IDLE;
    endcase
  end

  // NOTE: every flop here uses non-blocking assignment so all state updates together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LD_IDLE;
    else        state <= state_next;
  end

  // Outputs are registered from state_next so they line up with the ISSUE cycle.
  // NOTE: the assembly buffer doubles as mtx_in and must reset to '0, so it sits in the reset branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest      <= DEST_V0;
      k         <= '0;
      row       <= '0;
      col       <= '0;
      mtx_in    <= '0;
      err       <= 1'b0;
      issue     <= 1'b0;
      busy      <= 1'b0;
      vliw_inst <= NOP_BUNDLE;
    end else begin
      issue     <= (state_next == LD_ISSUE);
      busy      <= (state_next != LD_IDLE);
      vliw_inst <= (state_next == LD_ISSUE) ? load_bundle(dest) : NOP_BUNDLE;

      if (accept_cmd) begin
        if (legal_cmd) begin
          dest   <= ld_dest_t'(cmd_dest);
          k      <= '0;
          row    <= '0;
          col    <= '0;
          mtx_in <= '0;
        end else begin
          err <= 1'b1;
        end
      end else if (accept_elem) begin
        if (dest == DEST_M0)
          mtx_in.mtx.elements[row][col] <= val3_t'(s_data[$bits(val3_t)-1:0]);
        else
          mtx_in.vec.elements[k[VEC_W-1:0]] <= s_data;
        k <= k + 1'b1;
        // Row/column pair replaces k / C and k % C.
        if (col == COL_W'(C - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mtx_operand_loader.sv
// Directed bench for mtx_operand_loader: reset, vector and matrix loads,
// stalls, illegal commands, mid-fill reset, ignored stream and back-to-back.
module tb_mtx_operand_loader;
  import mtx_types::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_dest;
  logic       s_valid;
  logic       s_ready;
  qformat_t   s_data;
  vliw_inst_t vliw_inst;
  mv_t        mtx_in;
  logic       issue;
  logic       busy;
  logic       err;

  int n_vec;
  int n_bad;
  int cyc;
  int issue_cnt;
  int last_issue_cyc;
  int prev_issue_cyc;

  mtx_operand_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dest  (cmd_dest),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .vliw_inst (vliw_inst),
    .mtx_in    (mtx_in),
    .issue     (issue),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (issue === 1'b1) begin
      issue_cnt      = issue_cnt + 1;
      prev_issue_cyc = last_issue_cyc;
      last_issue_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] d);
    cmd_valid = 1'b1;
    cmd_dest  = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic send_elem(input qformat_t d);
    s_valid = 1'b1;
    s_data  = d;
    step();
  endtask

  task automatic test_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++; if (vliw_inst !== NOP_BUNDLE) begin n_bad++; $display("FAIL %s vliw_inst: got %h want %h", tag, vliw_inst, NOP_BUNDLE); end
    n_vec++; if (mtx_in !== '0) begin n_bad++; $display("FAIL %s mtx_in: got %h want 0", tag, mtx_in); end
    n_vec++; if ({issue, busy, err} !== 3'b000) begin n_bad++; $display("FAIL %s issue/busy/err: got %b want 000", tag, {issue, busy, err}); end
    n_vec++; if ({cmd_ready, s_ready} !== 2'b10) begin n_bad++; $display("FAIL %s cmd_ready/s_ready: got %b want 10", tag, {cmd_ready, s_ready}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_v0_load();
    qformat_t vals [4];
    vliw_inst_t want;
    vals[0] = 32'h0080_0000;  // 1.0
    vals[1] = 32'hFEC0_0000;  // -2.5
    vals[2] = 32'h0000_0000;  // 0.0
    vals[3] = 32'h01A0_0000;  // 3.25
    want = '{op1: LD_V0, op2: NOP, op3: NOP, op4: NOP};
    send_cmd(2'd0);
    n_vec++; if ({s_ready, cmd_ready, busy} !== 3'b101) begin n_bad++; $display("FAIL v0 fill entry s_ready/cmd_ready/busy: got %b want 101", {s_ready, cmd_ready, busy}); end
    for (int i = 0; i < 4; i++) send_elem(vals[i]);
    s_valid = 1'b0;
    n_vec++; if (issue !== 1'b1) begin n_bad++; $display("FAIL v0 issue: got %b want 1", issue); end
    n_vec++; if (vliw_inst !== want) begin n_bad++; $display("FAIL v0 bundle: got %h want %h", vliw_inst, want); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (mtx_in.vec.elements[i] !== vals[i]) begin n_bad++; $display("FAIL v0 elem%0d: got %h want %h", i, mtx_in.vec.elements[i], vals[i]); end
    end
    step();
    n_vec++; if ({cmd_ready, issue} !== 2'b10) begin n_bad++; $display("FAIL v0 after issue cmd_ready/issue: got %b want 10", {cmd_ready, issue}); end
    n_vec++; if (vliw_inst !== NOP_BUNDLE) begin n_bad++; $display("FAIL v0 after issue bundle: got %h want %h", vliw_inst, NOP_BUNDLE); end
  endtask

  task automatic test_m0_stall();
    int base;
    vliw_inst_t want;
    want = '{op1: LD_M0, op2: NOP, op3: NOP, op4: NOP};
    base = issue_cnt;
    send_cmd(2'd2);
    for (int i = 0; i < 16; i++) begin
      send_elem(32'hDEAD_BEE0 | i);
      s_valid = 1'b0;
      s_data  = 32'hFFFF_FFFF;
      if (i != 15) begin
        n_vec++; if (issue !== 1'b0) begin n_bad++; $display("FAIL m0 early issue at elem %0d: got %b want 0", i, issue); end
        step();
      end
    end
    n_vec++; if (issue !== 1'b1) begin n_bad++; $display("FAIL m0 issue: got %b want 1", issue); end
    n_vec++; if (vliw_inst !== want) begin n_bad++; $display("FAIL m0 bundle: got %h want %h", vliw_inst, want); end
    n_vec++; if (mtx_in.mtx.elements[2][3] !== 3'b011) begin n_bad++; $display("FAIL m0 [2][3]: got %b want 011", mtx_in.mtx.elements[2][3]); end
    n_vec++; if (mtx_in.mtx.elements[0][0] !== 3'b000) begin n_bad++; $display("FAIL m0 [0][0]: got %b want 000", mtx_in.mtx.elements[0][0]); end
    n_vec++; if (mtx_in.mtx.elements[1][2] !== 3'b110) begin n_bad++; $display("FAIL m0 [1][2]: got %b want 110", mtx_in.mtx.elements[1][2]); end
    n_vec++; if (mtx_in.mtx.elements[3][3] !== 3'b111) begin n_bad++; $display("FAIL m0 [3][3]: got %b want 111", mtx_in.mtx.elements[3][3]); end
    n_vec++; if (mtx_in.vec !== '0) begin n_bad++; $display("FAIL m0 vec untouched: got %h want 0", mtx_in.vec); end
    for (int i = 0; i < 3; i++) step();
    n_vec++; if (issue_cnt - base !== 1) begin n_bad++; $display("FAIL m0 pulse count: got %0d want 1", issue_cnt - base); end
  endtask

  task automatic test_illegal();
    int base;
    vliw_inst_t want;
    want = '{op1: LD_V1, op2: NOP, op3: NOP, op4: NOP};
    base = issue_cnt;
    send_cmd(2'd3);
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL illegal err: got %b want 1", err); end
    n_vec++; if ({busy, cmd_ready, s_ready} !== 3'b010) begin n_bad++; $display("FAIL illegal busy/cmd_ready/s_ready: got %b want 010", {busy, cmd_ready, s_ready}); end
    step();
    step();
    n_vec++; if (issue_cnt !== base) begin n_bad++; $display("FAIL illegal issue count: got %0d want %0d", issue_cnt, base); end
    send_cmd(2'd1);
    for (int i = 0; i < 4; i++) send_elem(qformat_t'(i + 1));
    s_valid = 1'b0;
    n_vec++; if (vliw_inst !== want) begin n_bad++; $display("FAIL illegal then v1 bundle: got %h want %h", vliw_inst, want); end
    n_vec++; if (mtx_in.vec.elements[3] !== 32'd4) begin n_bad++; $display("FAIL illegal then v1 elem3: got %h want 4", mtx_in.vec.elements[3]); end
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL err sticky: got %b want 1", err); end
    step();
  endtask

  task automatic test_mid_fill_reset();
    int base;
    mv_t want;
    want = '0;
    for (int i = 0; i < 4; i++) want.vec.elements[i] = 32'd7;
    send_cmd(2'd1);
    send_elem(32'd5);
    send_elem(32'd6);
    s_valid = 1'b0;
    test_reset("midfill");
    base = issue_cnt;
    send_cmd(2'd1);
    for (int i = 0; i < 4; i++) send_elem(32'd7);
    s_valid = 1'b0;
    n_vec++; if (mtx_in !== want) begin n_bad++; $display("FAIL midfill mtx_in: got %h want %h", mtx_in, want); end
    step();
    step();
    n_vec++; if (issue_cnt - base !== 1) begin n_bad++; $display("FAIL midfill pulse count: got %0d want 1", issue_cnt - base); end
  endtask

  task automatic test_ignored_idle();
    mv_t want;
    want = '0;
    for (int i = 0; i < 4; i++) want.vec.elements[i] = 32'd7;
    s_valid = 1'b1;
    s_data  = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL idle s_ready cycle %0d: got %b want 0", i, s_ready); end
      n_vec++; if (mtx_in !== want) begin n_bad++; $display("FAIL idle buffer cycle %0d: got %h want %h", i, mtx_in, want); end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    qformat_t a [4];
    qformat_t b [4];
    for (int i = 0; i < 4; i++) begin
      a[i] = qformat_t'(i + 1);
      b[i] = qformat_t'(i + 9);
    end
    send_cmd(2'd0);
    for (int i = 0; i < 4; i++) send_elem(a[i]);
    // ISSUE cycle: stream and command both offered, neither may be taken.
    s_data    = 32'hBAD0_BAD0;
    cmd_valid = 1'b1;
    cmd_dest  = 2'd0;
    n_vec++; if ({issue, s_ready, cmd_ready} !== 3'b100) begin n_bad++; $display("FAIL b2b issue cycle issue/s_ready/cmd_ready: got %b want 100", {issue, s_ready, cmd_ready}); end
    step();
    n_vec++; if (mtx_in.vec.elements[3] !== a[3]) begin n_bad++; $display("FAIL b2b buffer after issue: got %h want %h", mtx_in.vec.elements[3], a[3]); end
    n_vec++; if ({cmd_ready, s_ready} !== 2'b10) begin n_bad++; $display("FAIL b2b idle gap cmd_ready/s_ready: got %b want 10", {cmd_ready, s_ready}); end
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) send_elem(b[i]);
    s_valid = 1'b0;
    n_vec++; if (issue !== 1'b1) begin n_bad++; $display("FAIL b2b second issue: got %b want 1", issue); end
    n_vec++; if (mtx_in.vec.elements[0] !== b[0] || mtx_in.vec.elements[3] !== b[3]) begin n_bad++; $display("FAIL b2b second operand: got %h want %h_%h", mtx_in.vec, b[3], b[0]); end
    @(negedge clk);
    #1;
    n_vec++; if (last_issue_cyc - prev_issue_cyc !== 6) begin n_bad++; $display("FAIL b2b issue spacing: got %0d want 6", last_issue_cyc - prev_issue_cyc); end
    step();
  endtask

  initial begin
    n_vec          = 0;
    n_bad          = 0;
    cyc            = 0;
    issue_cnt      = 0;
    last_issue_cyc = 0;
    prev_issue_cyc = 0;
    rst_n          = 1'b1;
    cmd_valid      = 1'b0;
    cmd_dest       = 2'd0;
    s_valid        = 1'b0;
    s_data         = '0;

    test_reset("reset");
    test_v0_load();
    test_m0_stall();
    test_illegal();
    test_mid_fill_reset();
    test_ignored_idle();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
